ram_loader: RTL and testbench

RAM_LOADER -- requirements
Module: ram_loader

---
 rtl/loader_pkg.sv | 16 +
 rtl/load_addr_counter.sv | 29 ++
 rtl/ram_loader.sv | 105 ++++++++++
 tb/tb_ram_loader.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the RAM program loader: default geometry and FSM state encoding.
package loader_pkg;

  localparam int DEPTH_DEF  = 16;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BYTE,
    SET_ADDR,
    WRITE,
    RELEASE,
    DONE
  } state_t;

endpackage

// File: rtl/load_addr_counter.sv
// Target-address counter for the loader: synchronous zero, increment, terminal count at DEPTH-1.
module load_addr_counter
  import loader_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              zero,
  input  logic              inc,
  output logic [ADDR_W-1:0] count,
  output logic              tc
);

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      count <= '0;
    end else if (zero) begin
      count <= '0;
    end else if (inc) begin
      count <= count + ADDR_W'(1);
    end
  end

  assign tc = (count == ADDR_W'(DEPTH - 1));

endmodule

// File: rtl/ram_loader.sv
// Host-to-RAM program loader: holds the CPU, writes DEPTH bytes over the shared bus, then releases it.
module ram_loader
  import loader_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [7:0]        bus_out,
  output logic              bus_oe,
  output logic              marwa,
  output logic              ramwa,
  output logic              cpu_hold,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] addr
);

  state_t     state;
  logic [7:0] byte_q;
  logic       idle_start;
  logic       abort_ok;
  logic       last_addr;
  logic       addr_zero;
  logic       addr_inc;

  assign idle_start = start && (state == IDLE || state == DONE);
  // RELEASE is deliberately excluded so a finished image always hands the CPU back cleanly.
  assign abort_ok   = abort && (state == WAIT_BYTE || state == SET_ADDR || state == WRITE);

  // NOTE: always_comb gives every output a default first, so no path can infer a latch.
  always_comb begin
    addr_zero = 1'b0;
    addr_inc  = 1'b0;
    if (idle_start || abort_ok) begin
      addr_zero = 1'b1;
    end else if (state == WRITE && !last_addr) begin
      addr_inc = 1'b1;
    end
  end

  load_addr_counter #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_addr (
    .clk   (clk),
    .clr   (clr),
    .zero  (addr_zero),
    .inc   (addr_inc),
    .count (addr),
    .tc    (last_addr)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state  <= IDLE;
      byte_q <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (start) state <= WAIT_BYTE;
        WAIT_BYTE: begin
          if (abort) begin
            state <= IDLE;
          end else if (byte_valid) begin
            byte_q <= byte_in;
            state  <= SET_ADDR;
          end
        end
        SET_ADDR:  state <= abort ? IDLE : WRITE;
        WRITE: begin
          if (abort)          state <= IDLE;
          else if (last_addr) state <= RELEASE;
          else                state <= WAIT_BYTE;
        end
        RELEASE:   state <= DONE;
        default:   state <= IDLE;
      endcase
    end
  end

  // Bus strobes are pure state decodes, so marwa/ramwa are exclusive and always inside bus_oe.
  assign byte_ready = (state == WAIT_BYTE);
  assign marwa      = (state == SET_ADDR);
  assign ramwa      = (state == WRITE);
  assign bus_oe     = marwa || ramwa;
  assign cpu_rst    = (state == RELEASE);
  assign done       = (state == DONE);
  assign busy       = (state == WAIT_BYTE) || (state == SET_ADDR) ||
                      (state == WRITE) || (state == RELEASE);
  assign cpu_hold   = busy;

  always_comb begin
    bus_out = 8'h00;
    if (marwa)      bus_out = 8'(addr);
    else if (ramwa) bus_out = byte_q;
  end

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader: randomized host traffic against a cycle-level behavioural model.
module tb_ram_loader;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       byte_valid = 1'b0;
  logic       byte_ready;
  logic [7:0] bus_out;
  logic       bus_oe, marwa, ramwa, cpu_hold, cpu_rst, busy, done;
  logic [3:0] addr;

  int checks = 0;
  int errors = 0;

  ram_loader dut (
    .clk        (clk),
    .clr        (clr),
    .start      (start),
    .abort      (abort),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .bus_out    (bus_out),
    .bus_oe     (bus_oe),
    .marwa      (marwa),
    .ramwa      (ramwa),
    .cpu_hold   (cpu_hold),
    .cpu_rst    (cpu_rst),
    .busy       (busy),
    .done       (done),
    .addr       (addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Shared-bus RAM as the CPU side sees it: MAR latched on marwa, RAM written on ramwa.
  logic [7:0] dut_ram [16];
  logic [3:0] mar = 4'h0;
  initial for (int i = 0; i < 16; i++) dut_ram[i] = 8'h00;
  always @(posedge clk) begin
    if (marwa) mar = bus_out[3:0];
    if (ramwa) dut_ram[mar] = bus_out;
  end

  // Behavioural model: mode 0 idle, 1 loading (step 0 wait, 1 address, 2 write), 2 release, 3 done.
  int         m_mode = 0, m_step = 0, m_addr = 0;
  logic [7:0] m_byte = 8'h00;
  logic [7:0] exp_ram [16];
  initial for (int i = 0; i < 16; i++) exp_ram[i] = 8'h00;

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      m_mode = 0; m_step = 0; m_addr = 0; m_byte = 8'h00;
    end else begin
      case (m_mode)
        0, 3: if (start) begin m_mode = 1; m_step = 0; m_addr = 0; end
        1: begin
          if (abort) begin
            m_mode = 0; m_step = 0; m_addr = 0;
          end else if (m_step == 0) begin
            if (byte_valid) begin m_byte = byte_in; m_step = 1; end
          end else if (m_step == 1) begin
            m_step = 2;
          end else begin
            exp_ram[m_addr] = m_byte;
            if (m_addr == 15) m_mode = 2;
            else begin m_addr++; m_step = 0; end
          end
        end
        default: m_mode = 3;
      endcase
    end
  end

  always @(negedge clk) begin
    logic       e_mar, e_ram;
    logic [7:0] e_bus;
    e_mar = (m_mode == 1) && (m_step == 1);
    e_ram = (m_mode == 1) && (m_step == 2);
    e_bus = e_mar ? m_addr[7:0] : (e_ram ? m_byte : 8'h00);
    check("byte_ready", byte_ready, (m_mode == 1) && (m_step == 0));
    check("marwa",      marwa,      e_mar);
    check("ramwa",      ramwa,      e_ram);
    check("bus_oe",     bus_oe,     e_mar || e_ram);
    check("bus_out",    bus_out,    e_bus);
    check("cpu_hold",   cpu_hold,   (m_mode == 1) || (m_mode == 2));
    check("busy",       busy,       (m_mode == 1) || (m_mode == 2));
    check("cpu_rst",    cpu_rst,    m_mode == 2);
    check("done",       done,       m_mode == 3);
    check("addr",       addr,       m_addr[3:0]);
    check("enable_excl", marwa && ramwa, 1'b0);
    check("enable_oe",  (marwa || ramwa) && !bus_oe, 1'b0);
  end

  // Observation of load timing and cpu_rst pulses.
  int   ncyc = 0, t_busy = 0, t_rst = 0, rst_pulses = 0;
  logic busy_d = 1'b0;
  always @(negedge clk) begin
    ncyc++;
    if (busy && !busy_d) t_busy = ncyc;
    if (cpu_rst) begin t_rst = ncyc; rst_pulses++; end
    busy_d = busy;
  end

  task automatic begin_load();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic load(input logic [7:0] base, input bit gaps, input bit mid_start);
    int cyc = 0;
    begin_load();
    while (done !== 1'b1 && cyc < 400) begin
      byte_in    = base + 8'(addr);
      byte_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      start      = mid_start && (cyc % 17 == 5);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; byte_valid = 1'b0;
    check("load_done", done, 1'b1);
  endtask

  task automatic cmp_ram(input string tag);
    for (int i = 0; i < 16; i++) check($sformatf("%s_ram%0d", tag, i), dut_ram[i], exp_ram[i]);
  endtask

  task automatic outputs_zero(input string tag);
    check({tag, "_oe"},    bus_oe,   1'b0);
    check({tag, "_bus"},   bus_out,  8'h00);
    check({tag, "_mw"},    marwa,    1'b0);
    check({tag, "_rw"},    ramwa,    1'b0);
    check({tag, "_hold"},  cpu_hold, 1'b0);
    check({tag, "_rst"},   cpu_rst,  1'b0);
    check({tag, "_busy"},  busy,     1'b0);
    check({tag, "_done"},  done,     1'b0);
    check({tag, "_ready"}, byte_ready, 1'b0);
    check({tag, "_addr"},  addr,     4'h0);
  endtask

  initial begin
    int guard;
    #1 clr = 1'b0;
    #1 outputs_zero("reset");
    @(negedge clk); @(negedge clk);
    #2 clr = 1'b1;

    // Full image with byte_valid held high.
    rst_pulses = 0;
    load(8'h10, 1'b0, 1'b0);
    check("rst_cycle", t_rst - t_busy, 48);
    check("rst_pulses", rst_pulses, 1);
    check("img1_hold", cpu_hold, 1'b0);
    check("img1_addr", addr, 4'hF);
    for (int i = 0; i < 16; i++) check($sformatf("img1_lit%0d", i), dut_ram[i], 8'h10 + 8'(i));
    cmp_ram("img1");

    // Restart from DONE with random gaps and stray start pulses mid-load.
    load(8'h30, 1'b1, 1'b1);
    cmp_ram("img2");
    check("img2_lit7", dut_ram[7], 8'h37);

    // Abort while presenting address 5.
    rst_pulses = 0;
    begin_load();
    guard = 0;
    byte_valid = 1'b1;
    while (!(marwa === 1'b1 && addr == 4'd5) && guard < 100) begin
      byte_in = 8'h50 + 8'(addr);
      @(negedge clk); guard++;
    end
    check("abort5_reached", guard < 100, 1'b1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; byte_valid = 1'b0;
    check("abort5_busy", busy, 1'b0);
    check("abort5_hold", cpu_hold, 1'b0);
    check("abort5_rstp", rst_pulses, 0);
    check("abort5_lit4", dut_ram[4], 8'h54);
    check("abort5_lit5", dut_ram[5], 8'h35);
    cmp_ram("abort5");

    // Abort coincident with the handshake of 8'hAA at address 3.
    begin_load();
    guard = 0;
    byte_valid = 1'b1;
    while (!(byte_ready === 1'b1 && addr == 4'd3) && guard < 100) begin
      byte_in = 8'h60 + 8'(addr);
      @(negedge clk); guard++;
    end
    check("abortaa_reached", guard < 100, 1'b1);
    byte_in = 8'hAA; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; byte_valid = 1'b0;
    check("abortaa_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    check("abortaa_lit3", dut_ram[3], 8'h53);
    check("abortaa_lit2", dut_ram[2], 8'h62);
    cmp_ram("abortaa");

    // Reset pulsed during the write of address 9.
    begin_load();
    guard = 0;
    byte_valid = 1'b1;
    while (!(ramwa === 1'b1 && addr == 4'd9) && guard < 100) begin
      byte_in = 8'h70 + 8'(addr);
      @(negedge clk); guard++;
    end
    check("clr9_reached", guard < 100, 1'b1);
    #2 clr = 1'b0;
    #1 outputs_zero("clr9");
    byte_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    #2 clr = 1'b1;
    check("clr9_lit8", dut_ram[8], 8'h78);
    check("clr9_lit9", dut_ram[9], 8'h39);
    cmp_ram("clr9");
    load(8'h80, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) check($sformatf("img3_lit%0d", i), dut_ram[i], 8'h80 + 8'(i));
    cmp_ram("img3");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
